// File: rtl/apc_stim_gen.sv
// Multi-channel complex-sample stimulus generator: round-robin channel beats on a
// valid/ready stream with CONST/RAMP/LFSR/TAG patterns, burst framing and inter-frame gaps.
module apc_stim_gen #(
    parameter int DATA_BITS = 32,
    parameter int NUM_CH    = 4,
    parameter int LEN_BITS  = 16,
    parameter int GAP_BITS  = 8,
    localparam int CH_BITS  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           mode,
    input  logic [LEN_BITS-1:0]  burst_len,
    input  logic [GAP_BITS-1:0]  gap,
    input  logic [DATA_BITS-1:0] const_re,
    input  logic [DATA_BITS-1:0] const_im,
    input  logic [31:0]          seed,
    output logic [DATA_BITS-1:0] data_re,
    output logic [DATA_BITS-1:0] data_im,
    output logic                 valid,
    input  logic                 ready,
    output logic [CH_BITS-1:0]   ch,
    output logic                 last,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;
    typedef enum logic [1:0] {P_CONST, P_RAMP, P_LFSR, P_TAG} pat_t;

    localparam logic [31:0]        LFSR_MASK = 32'h8020_0003;
    localparam logic [CH_BITS-1:0] CH_LAST   = CH_BITS'(NUM_CH - 1);

    state_t                 state_q, state_d;
    pat_t                   mode_q, mode_d;
    logic [LEN_BITS-1:0]    len_q, len_d;
    logic [GAP_BITS-1:0]    gap_q, gap_d;
    logic [DATA_BITS-1:0]   cre_q, cre_d;
    logic [DATA_BITS-1:0]   cim_q, cim_d;
    logic [LEN_BITS-1:0]    n_q, n_d;
    logic [CH_BITS-1:0]     c_q, c_d;
    logic [GAP_BITS-1:0]    gcnt_q, gcnt_d;
    logic [31:0]            lfsr_q, lfsr_d;
    logic [DATA_BITS-1:0]   ramp_q, ramp_d;

    logic                   accept;
    logic                   final_beat;
    logic [31:0]            lfsr_next;
    logic [DATA_BITS-1:0]   pat_re, pat_im;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mode_q  <= P_CONST;
            len_q   <= '0;
            gap_q   <= '0;
            cre_q   <= '0;
            cim_q   <= '0;
            n_q     <= '0;
            c_q     <= '0;
            gcnt_q  <= '0;
            lfsr_q  <= 32'd1;
            ramp_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            cre_q   <= cre_d;
            cim_q   <= cim_d;
            n_q     <= n_d;
            c_q     <= c_d;
            gcnt_q  <= gcnt_d;
            lfsr_q  <= lfsr_d;
            ramp_q  <= ramp_d;
        end
    end

    always_comb begin
        accept     = (state_q == S_RUN) && ready;
        final_beat = (n_q == len_q - LEN_BITS'(1)) && (c_q == CH_LAST);
        lfsr_next  = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_MASK : 32'd0);
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        gap_d   = gap_q;
        cre_d   = cre_q;
        cim_d   = cim_q;
        n_d     = n_q;
        c_d     = c_q;
        gcnt_d  = gcnt_q;
        lfsr_d  = lfsr_q;
        ramp_d  = ramp_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        mode_d  = pat_t'(mode);
                        len_d   = burst_len;
                        gap_d   = gap;
                        cre_d   = const_re;
                        cim_d   = const_im;
                        lfsr_d  = (seed == 32'd0) ? 32'd1 : seed;
                        n_d     = '0;
                        c_d     = '0;
                        ramp_d  = '0;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    lfsr_d = lfsr_next;
                    // Running beat count stands in for n*NUM_CH + c.
                    ramp_d = ramp_q + DATA_BITS'(1);
                    if (final_beat) begin
                        state_d = S_DONE;
                    end else if (c_q == CH_LAST) begin
                        c_d = '0;
                        n_d = n_q + LEN_BITS'(1);
                        if (gap_q != '0) begin
                            gcnt_d  = gap_q;
                            state_d = S_GAP;
                        end
                    end else begin
                        c_d = c_q + CH_BITS'(1);
                    end
                end
            end
            S_GAP: begin
                if (gcnt_q <= GAP_BITS'(1)) begin
                    gcnt_d  = '0;
                    state_d = S_RUN;
                end else begin
                    gcnt_d = gcnt_q - GAP_BITS'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over a same-cycle accept, so the LFSR must not advance either.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            n_d     = '0;
            c_d     = '0;
            gcnt_d  = '0;
            ramp_d  = '0;
            lfsr_d  = lfsr_q;
        end
    end

    always_comb begin
        pat_re = cre_q;
        pat_im = cim_q;
        unique case (mode_q)
            P_CONST: begin
                pat_re = cre_q;
                pat_im = cim_q;
            end
            P_RAMP: begin
                pat_re = ramp_q;
                pat_im = ~ramp_q;
            end
            P_LFSR: begin
                pat_re = DATA_BITS'(lfsr_q);
                pat_im = DATA_BITS'(~lfsr_q);
            end
            P_TAG: begin
                pat_re = DATA_BITS'(n_q);
                pat_re[DATA_BITS-1 -: CH_BITS] = c_q;
                pat_im = cim_q;
            end
            default: begin
                pat_re = cre_q;
                pat_im = cim_q;
            end
        endcase
    end

    always_comb begin
        valid   = (state_q == S_RUN);
        busy    = (state_q == S_RUN) || (state_q == S_GAP);
        done    = (state_q == S_DONE);
        data_re = valid ? pat_re : '0;
        data_im = valid ? pat_im : '0;
        ch      = valid ? c_q : '0;
        last    = valid && final_beat;
    end

endmodule

// File: doc/apc_stim_gen.md
Name: apc_stim_gen

Overview:
- Parametrised multi-channel complex-sample stimulus generator that feeds APC datapaths in simulation and on-chip self-test.
- Emits round-robin-interleaved channel samples (re/im) on a valid/ready stream.
- Supports programmable pattern mode, burst length and inter-frame gap.
- Successor to the fixed single-channel, valid-only APC stimulus bundle: adds backpressure, channel tagging, framing and pattern modes.

Parameters:
- DATA_BITS, 32, width of each of re and im.
- NUM_CH, 4, channels interleaved per frame (>=1). Localparam CH_BITS = max(1, clog2(NUM_CH)).
- LEN_BITS, 16, width of burst_len.
- GAP_BITS, 8, width of gap.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle start request.
- abort  in  1  terminate current burst.
- mode  in  2  pattern select: 0 CONST, 1 RAMP, 2 LFSR, 3 TAG.
- burst_len  in  LEN_BITS  frames per burst (samples per channel).
- gap  in  GAP_BITS  idle cycles inserted after each frame.
- const_re  in  DATA_BITS  CONST-mode real value.
- const_im  in  DATA_BITS  CONST/TAG-mode imaginary value.
- seed  in  32  LFSR seed.
- data_re  out  DATA_BITS  real sample.
- data_im  out  DATA_BITS  imaginary sample.
- valid  out  1  sample valid.
- ready  in  1  downstream accept.
- ch  out  CH_BITS  channel index of current sample.
- last  out  1  final beat of burst.
- busy  out  1  high in RUN or GAP.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM to IDLE, counters n=0 and c=0, lfsr=1.
- Beat accept = valid && ready.
- Output stability: while valid=1 and ready=0, data_re/data_im/ch/last hold stable.
- FSM states: IDLE, RUN, GAP, DONE.
- IDLE:
  - start=1 and burst_len!=0: latch mode, burst_len, gap, const_re, const_im and seed (seed 0 is replaced by 1); n=0, c=0; go to RUN. valid is high the cycle after start.
  - start=1 and burst_len==0: go to DONE; no beats are emitted.
- RUN:
  - valid=1 and busy=1.
  - On accept, if n==burst_len-1 and c==NUM_CH-1 (last=1): go to DONE.
  - On accept, else if c==NUM_CH-1: c=0, n=n+1; if gap!=0, load the gap counter and go to GAP.
  - On accept, otherwise: c=c+1.
- GAP: valid=0, busy=1; count down for exactly gap cycles, then return to RUN.
- DONE: done=1 for one cycle, valid=0, busy=0; return to IDLE.
- abort=1 in any non-IDLE state: next cycle state is IDLE, valid=0, no done pulse, counters cleared. abort has priority over accept.
- start while busy: ignored. Latched configuration is unaffected by input changes during a burst.
- Pattern per beat (n = frame index, c = channel):
  - CONST: re=const_re, im=const_im.
  - RAMP: re = (n*NUM_CH + c) mod 2^DATA_BITS; im = bitwise NOT of re.
  - LFSR: 32-bit right-shift Galois LFSR with mask 0x80200003. Advances only on accept: lsb=l[0]; l=l>>1; if lsb, l^=mask. re = l, im = ~l, each truncated or zero-extended to DATA_BITS.
  - TAG: re = n zero-extended to DATA_BITS, with c placed in the top CH_BITS bits; im = const_im.
- last is high only on the final beat of the burst.
- n wraps only through burst_len; the ramp value wraps modulo 2^DATA_BITS.

Test Plan:
- NUM_CH=4, RAMP, burst_len=3, gap=0, ready=1 -> 12 consecutive beats: re=0..11, im=~re, ch=0,1,2,3 repeating, last on beat 12, done the next cycle, busy then 0.
- Same config with ready toggling 1,0,0,1,… -> identical beat sequence; data held constant during every stall; total 12 accepts.
- RAMP, burst_len=2, gap=2 -> 4 beats, valid low for exactly 2 cycles, 4 beats; no gap after the final frame.
- LFSR, seed=1, NUM_CH=1, burst_len=3 -> re = 0x00000001, 0x80200003, 0xC0300002; im = bitwise complements; a stall does not advance the LFSR.
- Abort asserted after 5 accepts of a 12-beat burst -> valid=0 the next cycle, no done pulse, busy=0; a following start produces re starting from 0.
- rst asserted mid-burst -> outputs 0 immediately (async). burst_len=0 start -> done pulse, zero beats. start during busy -> no effect.
